// File: rtl/mem_bus_sequencer_pkg.sv
// Shared definitions for the memory bus sequencer: word width, FSM state
// encodings and grant-source encoding.
package mem_bus_sequencer_pkg;

    localparam int DEF_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_bus_sequencer_timeout.sv
// Handshake watchdog: counts cycles while an access is in flight and flags
// the last allowed cycle so the sequencer can abort on the following edge.
module mem_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] cnt_q;

    // Restart on access entry, advance every in-flight cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cnt_q <= '0;
        else if (clear)  cnt_q <= '0;
        else if (enable) cnt_q <= cnt_q + 1'b1;
    end

    // Count starts at 0 in the first strobe cycle, so LIMIT-1 marks the last one.
    assign expired = enable && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: shares one memory port between instruction fetch
// and data memory, DM has priority, one access in flight at a time.
// Optional watchdog abort enabled by defining MEM_TIMEOUT_EN.
module mem_bus_sequencer
    import mem_bus_sequencer_pkg::*;
#(
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_done,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 dm_done,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 busy,
    output logic                 err
);
    state_e state_q, state_d;
    gnt_e   gnt_q, gnt_d;

    logic                 if_pend_q, if_pend_d, dm_pend_q, dm_pend_d;
    logic                 dm_we_q, dm_we_d;
    logic [WORD_SIZE-1:0] if_addr_q, if_addr_d, dm_addr_q, dm_addr_d;
    logic [WORD_SIZE-1:0] dm_wdata_q, dm_wdata_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic                 readM_q, readM_d, writeM_q, writeM_d;
    logic                 if_done_q, if_done_d, dm_done_q, dm_done_d;

    logic if_acc, dm_acc, if_pend_eff, dm_pend_eff, dm_we_eff, grant;
    logic hs, abort, finish;
    logic [WORD_SIZE-1:0] if_addr_eff, dm_addr_eff;

    // A request is dropped only while its own port is pending or in flight;
    // in the done cycle the FSM is already idle, so a new request is taken.
    assign if_acc = if_req && !if_pend_q && !(state_q != ST_IDLE && gnt_q == GNT_IF);
    assign dm_acc = dm_req && !dm_pend_q && !(state_q != ST_IDLE && gnt_q == GNT_DM);

    // Arbitrate on latched plus same-cycle requests so the strobe follows
    // the request by one cycle.
    assign if_pend_eff = if_pend_q | if_acc;
    assign dm_pend_eff = dm_pend_q | dm_acc;
    assign if_addr_eff = if_pend_q ? if_addr_q : if_addr;
    assign dm_addr_eff = dm_pend_q ? dm_addr_q : dm_addr;
    assign dm_we_eff   = dm_pend_q ? dm_we_q   : dm_we;
    assign grant       = (state_q == ST_IDLE) && (if_pend_eff || dm_pend_eff);

    assign hs     = (state_q == ST_RD && inputReady) || (state_q == ST_WR && ackOutput);
    assign finish = hs || abort;

`ifdef MEM_TIMEOUT_EN
    logic expired, err_q;

    mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant),
        .enable (state_q != ST_IDLE),
        .expired(expired)
    );

    // A handshake on the final allowed cycle still wins over the abort.
    assign abort = expired && !hs;

    // Error flag pulses alongside the done of an aborted access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= abort;
    end
    assign err = err_q;
`else
    logic unused_tc;
    assign unused_tc = (TIMEOUT_CYCLES == 0);
    assign abort     = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_IF;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next state: grant DM first, return to IDLE on handshake or abort.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: if (grant) begin
                gnt_d   = dm_pend_eff ? GNT_DM : GNT_IF;
                state_d = (dm_pend_eff && dm_we_eff) ? ST_WR : ST_RD;
            end
            ST_RD, ST_WR: if (finish) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath: request latches, registered strobes, completion.
    always_comb begin
        if_pend_d  = if_pend_eff;
        dm_pend_d  = dm_pend_eff;
        if_addr_d  = if_acc ? if_addr  : if_addr_q;
        dm_addr_d  = dm_acc ? dm_addr  : dm_addr_q;
        dm_we_d    = dm_acc ? dm_we    : dm_we_q;
        dm_wdata_d = dm_acc ? dm_wdata : dm_wdata_q;
        address_d  = address_q;
        readM_d    = (state_d == ST_RD);
        writeM_d   = (state_d == ST_WR);
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if (grant) begin
            if (dm_pend_eff) begin
                dm_pend_d = 1'b0;
                address_d = dm_addr_eff;
            end else begin
                if_pend_d = 1'b0;
                address_d = if_addr_eff;
            end
        end
        if (state_q != ST_IDLE && finish) begin
            if (gnt_q == GNT_IF) begin
                if_done_d = 1'b1;
                if (hs) if_rdata_d = data;
            end else begin
                dm_done_d = 1'b1;
                if (hs && state_q == ST_RD) dm_rdata_d = data;
            end
        end
    end

    // Datapath and memory-side registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pend_q  <= 1'b0;
            dm_pend_q  <= 1'b0;
            if_addr_q  <= '0;
            dm_addr_q  <= '0;
            dm_we_q    <= 1'b0;
            dm_wdata_q <= '0;
            address_q  <= '0;
            readM_q    <= 1'b0;
            writeM_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            if_pend_q  <= if_pend_d;
            dm_pend_q  <= dm_pend_d;
            if_addr_q  <= if_addr_d;
            dm_addr_q  <= dm_addr_d;
            dm_we_q    <= dm_we_d;
            dm_wdata_q <= dm_wdata_d;
            address_q  <= address_d;
            readM_q    <= readM_d;
            writeM_q   <= writeM_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    // DM write data is stable while in flight, so it drives the bus directly.
    assign data     = writeM_q ? dm_wdata_q : {WORD_SIZE{1'bz}};
    assign readM    = readM_q;
    assign writeM   = writeM_q;
    assign address  = address_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_done  = if_done_q;
    assign dm_done  = dm_done_q;
    assign busy     = (state_q != ST_IDLE) || if_pend_q || dm_pend_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Scoreboard bench for mem_bus_sequencer: stimulus pushes expected
// completions, a monitor pops and checks them on every done pulse.
module tb_mem_bus_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic if_req, dm_req, dm_we, inputReady, ackOutput;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, address;
    logic if_done, dm_done, readM, writeM, busy, err;
    wire  [15:0] data;
    logic mem_drive;
    logic [15:0] mem_val;

    assign data = mem_drive ? mem_val : 16'hzzzz;

    always #5 clk = ~clk;

    mem_bus_sequencer #(.WORD_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy), .err(err)
    );

    typedef struct {
        bit          dm;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_chk = 0;
    int n_fail = 0;
    int rd_cyc = 0;
    int base;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (readM) rd_cyc <= rd_cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_done || dm_done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: if_done=%b dm_done=%b", if_done, dm_done);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_port_dm", {31'd0, dm_done}, {31'd0, mon_e.dm});
                    chk("done_single", {31'd0, if_done ^ dm_done}, 32'd1);
                    chk(mon_e.dm ? "dm_rdata" : "if_rdata",
                        {16'd0, mon_e.dm ? dm_rdata : if_rdata}, {16'd0, mon_e.rdata});
                    chk("err_with_done", {31'd0, err}, {31'd0, mon_e.err});
                end
            end else if (err) begin
                chk("err_without_done", {31'd0, err}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; inputReady = 0; ackOutput = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_drive = 0; mem_val = 0;
        tick(); tick();
        chk("rst_readM", {31'd0, readM}, 0);
        chk("rst_writeM", {31'd0, writeM}, 0);
        chk("rst_address", {16'd0, address}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dones", {30'd0, if_done, dm_done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        reset = 1'b0;
        mem_drive = 1; mem_val = 16'h5A5A; #1;
        chk("rst_data_released", {16'd0, data}, 32'h5A5A);
        mem_drive = 0;

        // 1: IF read, memory answers in the third strobe cycle
        tick(); base = rd_cyc;
        if_req = 1; if_addr = 16'h0010;
        sb.push_back('{dm: 1'b0, rdata: 16'hA5A5, err: 1'b0});
        tick(); if_req = 0;
        chk("t1_readM", {31'd0, readM}, 1);
        chk("t1_address", {16'd0, address}, 32'h0010);
        chk("t1_busy", {31'd0, busy}, 1);
        tick();
        tick(); inputReady = 1; mem_drive = 1; mem_val = 16'hA5A5;
        tick(); inputReady = 0; mem_drive = 0;
        chk("t1_readM_drop", {31'd0, readM}, 0);
        chk("t1_readM_cycles", rd_cyc - base, 3);
        tick();
        chk("t1_idle", {31'd0, busy}, 0);

        // 2: DM write
        tick(); dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        sb.push_back('{dm: 1'b1, rdata: 16'h0000, err: 1'b0});
        tick(); dm_req = 0;
        chk("t2_writeM", {31'd0, writeM}, 1);
        chk("t2_readM", {31'd0, readM}, 0);
        chk("t2_address", {16'd0, address}, 32'h0200);
        chk("t2_data", {16'd0, data}, 32'h1234);
        tick();
        chk("t2_data_hold", {16'd0, data}, 32'h1234);
        ackOutput = 1;
        tick(); ackOutput = 0;
        chk("t2_writeM_drop", {31'd0, writeM}, 0);
        mem_drive = 1; mem_val = 16'h5A5A; #1;
        chk("t2_data_released", {16'd0, data}, 32'h5A5A);
        mem_drive = 0;
        tick();

        // 3: simultaneous IF and DM reads, DM first
        tick(); if_req = 1; if_addr = 16'h0020;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0300;
        sb.push_back('{dm: 1'b1, rdata: 16'hBEEF, err: 1'b0});
        sb.push_back('{dm: 1'b0, rdata: 16'h1111, err: 1'b0});
        tick(); if_req = 0; dm_req = 0;
        chk("t3_dm_readM", {31'd0, readM}, 1);
        chk("t3_dm_address", {16'd0, address}, 32'h0300);
        inputReady = 1; mem_drive = 1; mem_val = 16'hBEEF;
        tick(); inputReady = 0; mem_drive = 0;
        chk("t3_strobe_gap", {31'd0, readM}, 0);
        chk("t3_if_pending", {31'd0, busy}, 1);
        tick();
        chk("t3_if_readM", {31'd0, readM}, 1);
        chk("t3_if_address", {16'd0, address}, 32'h0020);
        inputReady = 1; mem_drive = 1; mem_val = 16'h1111;
        tick(); inputReady = 0; mem_drive = 0;
        tick();

        // 4: reset mid-read aborts silently
        tick(); if_req = 1; if_addr = 16'h0040;
        tick(); if_req = 0;
        chk("t4_readM", {31'd0, readM}, 1);
        #2 reset = 1;
        #1;
        chk("t4_async_readM", {31'd0, readM}, 0);
        chk("t4_busy", {31'd0, busy}, 0);
        tick(); tick();
        chk("t4_rdata_cleared", {if_rdata, dm_rdata}, 0);
        reset = 0;
        tick(); if_req = 1; if_addr = 16'h0050;
        sb.push_back('{dm: 1'b0, rdata: 16'h2222, err: 1'b0});
        tick(); if_req = 0;
        chk("t4_address", {16'd0, address}, 32'h0050);
        inputReady = 1; mem_drive = 1; mem_val = 16'h2222;
        tick(); inputReady = 0; mem_drive = 0;
        tick();

        // 5: wrong-type handshakes are ignored
        tick(); dm_req = 1; dm_we = 1; dm_addr = 16'h0400; dm_wdata = 16'h5678;
        sb.push_back('{dm: 1'b1, rdata: 16'h0000, err: 1'b0});
        tick(); dm_req = 0; inputReady = 1;
        chk("t5_writeM", {31'd0, writeM}, 1);
        tick(); inputReady = 0;
        chk("t5_writeM_hold", {31'd0, writeM}, 1);
        chk("t5_no_early_done", {31'd0, dm_done}, 0);
        ackOutput = 1;
        tick(); ackOutput = 0;
        chk("t5_writeM_drop", {31'd0, writeM}, 0);
        tick(); if_req = 1; if_addr = 16'h0060;
        sb.push_back('{dm: 1'b0, rdata: 16'h3333, err: 1'b0});
        tick(); if_req = 0; ackOutput = 1;
        chk("t5_readM", {31'd0, readM}, 1);
        tick(); ackOutput = 0;
        chk("t5_readM_hold", {31'd0, readM}, 1);
        chk("t5_no_early_if_done", {31'd0, if_done}, 0);
        inputReady = 1; mem_drive = 1; mem_val = 16'h3333;
        tick(); inputReady = 0; mem_drive = 0;
        chk("t5_readM_drop", {31'd0, readM}, 0);
        tick();

`ifdef MEM_TIMEOUT_EN
        // 6: watchdog abort after 4 strobe cycles, rdata kept
        tick(); base = rd_cyc; if_req = 1; if_addr = 16'h0070;
        sb.push_back('{dm: 1'b0, rdata: 16'h3333, err: 1'b1});
        tick(); if_req = 0;
        tick(); tick(); tick(); tick();
        chk("t6_readM_drop", {31'd0, readM}, 0);
        chk("t6_readM_cycles", rd_cyc - base, 4);
        tick();
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("sb_drained", sb.size(), 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
